// File: rtl/csr_trap_seq.sv
// Trap-entry / MRET sequencer driving the CSR file read port and three write ports.
// Optional: define CSR_TRAP_VECTORED_EN to honour mtvec vectored mode for interrupts.
module csr_trap_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_valid,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_tval,
    input  logic        mret_valid,
    output logic        ready,
    output logic [11:0] read_target,
    input  logic [63:0] read_data,
    output logic        wdEn,
    output logic        wdEn2,
    output logic        wdEn3,
    output logic [11:0] write_target,
    output logic [11:0] write_target2,
    output logic [11:0] write_target3,
    output logic [63:0] write_data,
    output logic [63:0] write_data2,
    output logic [63:0] write_data3,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [1:0]  priv_mode
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {IDLE, RD_VEC, RD_STATUS, WR_MAIN, WR_TVAL, REDIRECT} state_t;

    state_t      state, state_nx;
    logic        is_mret;
    logic [63:0] pc_q, cause_q, tval_q, vec_q, st_q;
    logic [1:0]  priv_q;
    logic [63:0] trap_tgt;
    logic [63:0] st_trap, st_mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            priv_mode <= 2'd3;
            is_mret   <= 1'b0;
            pc_q      <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            vec_q     <= '0;
            st_q      <= '0;
            priv_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (trap_valid || mret_valid) begin
                    is_mret <= !trap_valid;
                    pc_q    <= trap_pc;
                    cause_q <= trap_cause;
                    tval_q  <= trap_tval;
                    priv_q  <= priv_mode;
                end
                RD_VEC:    vec_q <= read_data;
                RD_STATUS: st_q  <= read_data;
                REDIRECT:  priv_mode <= is_mret ? st_q[12:11] : 2'd3;
                default: ;
            endcase
        end
    end

`ifdef CSR_TRAP_VECTORED_EN
    always_comb begin
        trap_tgt = {vec_q[63:2], 2'b00};
        if (vec_q[1:0] == 2'b01 && cause_q[63])
            trap_tgt = {vec_q[63:2], 2'b00} + {cause_q[61:0], 2'b00};
    end
`else
    assign trap_tgt = {vec_q[63:2], 2'b00};
`endif

    // MIE/MPIE/MPP shuffles for trap entry and return
    always_comb begin
        st_trap        = st_q;
        st_trap[7]     = st_q[3];
        st_trap[3]     = 1'b0;
        st_trap[12:11] = priv_q;
        st_mret        = st_q;
        st_mret[3]     = st_q[7];
        st_mret[7]     = 1'b1;
        st_mret[12:11] = 2'b00;
    end

    always_comb begin
        state_nx       = state;
        ready          = 1'b0;
        read_target    = '0;
        wdEn           = 1'b0;
        wdEn2          = 1'b0;
        wdEn3          = 1'b0;
        write_target   = '0;
        write_target2  = '0;
        write_target3  = '0;
        write_data     = '0;
        write_data2    = '0;
        write_data3    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (trap_valid || mret_valid) state_nx = RD_VEC;
            end
            RD_VEC: begin
                read_target = is_mret ? CSR_MEPC : CSR_MTVEC;
                state_nx    = RD_STATUS;
            end
            RD_STATUS: begin
                read_target = CSR_MSTATUS;
                state_nx    = WR_MAIN;
            end
            WR_MAIN: begin
                wdEn         = 1'b1;
                write_target = CSR_MSTATUS;
                if (is_mret) begin
                    write_data = st_mret;
                    state_nx   = REDIRECT;
                end else begin
                    write_data    = st_trap;
                    wdEn2         = 1'b1;
                    write_target2 = CSR_MEPC;
                    write_data2   = {pc_q[63:1], 1'b0};
                    wdEn3         = 1'b1;
                    write_target3 = CSR_MCAUSE;
                    write_data3   = cause_q;
                    state_nx      = WR_TVAL;
                end
            end
            WR_TVAL: begin
                wdEn         = 1'b1;
                write_target = CSR_MTVAL;
                write_data   = tval_q;
                state_nx     = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = is_mret ? vec_q : trap_tgt;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // a reset cycle cancels the write still pending in this state
        if (rst) begin
            wdEn  = 1'b0;
            wdEn2 = 1'b0;
            wdEn3 = 1'b0;
        end
    end
endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq: CSR file model, write/redirect scoreboard queues.
module tb_csr_trap_seq;
    logic        clk = 0;
    logic        rst;
    logic        trap_valid, mret_valid;
    logic [63:0] trap_cause, trap_pc, trap_tval;
    logic        ready;
    logic [11:0] read_target;
    logic [63:0] read_data;
    logic        wdEn, wdEn2, wdEn3;
    logic [11:0] write_target, write_target2, write_target3;
    logic [63:0] write_data, write_data2, write_data3;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  priv_mode;

    csr_trap_seq dut (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
        .ready(ready), .read_target(read_target), .read_data(read_data),
        .wdEn(wdEn), .wdEn2(wdEn2), .wdEn3(wdEn3),
        .write_target(write_target), .write_target2(write_target2), .write_target3(write_target3),
        .write_data(write_data), .write_data2(write_data2), .write_data3(write_data3),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .priv_mode(priv_mode)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] t; logic [63:0] d; } wr_t;
    typedef struct { logic [63:0] pc; int cyc; } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    logic [63:0] csr [0:4095];
    assign read_data = csr[read_target];

    int checks = 0, errors = 0, cyc = 0;
    logic [63:0] m_status, m_tvec, m_epc;
    logic [1:0]  m_priv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input logic [11:0] t, input logic [63:0] d);
        wr_t e;
        if (wq.size() == 0) begin
            chk("unexpected_write", {52'd0, t}, 64'hffff);
        end else begin
            e = wq.pop_front();
            chk("wr_target", {52'd0, t}, {52'd0, e.t});
            chk("wr_data", d, e.d);
        end
    endtask

    // CSR file: writes land on negedge, after the scoreboard has looked at them
    always @(negedge clk) begin
        rd_t r;
        if (wdEn)  chk_wr(write_target, write_data);
        if (wdEn2) chk_wr(write_target2, write_data2);
        if (wdEn3) chk_wr(write_target3, write_data3);
        if (redirect_valid) begin
            if (rq.size() == 0) chk("unexpected_redirect", redirect_pc, 64'hffff_ffff_ffff_ffff);
            else begin
                r = rq.pop_front();
                chk("redirect_pc", redirect_pc, r.pc);
                chk("redirect_cyc", 64'(cyc), 64'(r.cyc));
            end
        end
        if (wdEn)  csr[write_target]  = write_data;
        if (wdEn2) csr[write_target2] = write_data2;
        if (wdEn3) csr[write_target3] = write_data3;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin step(); n++; end
        chk("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    // Predict a trap accepted in cycle c0; push writes (optionally without mtval/redirect)
    task automatic exp_trap(input logic [63:0] pc, cause, tval, input int c0, input bit full);
        logic [63:0] st, tgt;
        st = m_status;
        st[7] = m_status[3];
        st[3] = 1'b0;
        st[12:11] = m_priv;
        wq.push_back('{12'h300, st});
        wq.push_back('{12'h341, pc & ~64'd1});
        wq.push_back('{12'h342, cause});
        m_status = st;
        m_epc = pc & ~64'd1;
        tgt = m_tvec & ~64'd3;
`ifdef CSR_TRAP_VECTORED_EN
        if (m_tvec[1:0] == 2'b01 && cause[63]) tgt = tgt + ({1'b0, cause[62:0]} << 2);
`endif
        if (full) begin
            wq.push_back('{12'h343, tval});
            rq.push_back('{tgt, c0 + 5});
        end
        m_priv = 2'd3;
    endtask

    task automatic exp_mret(input int c0);
        logic [63:0] st;
        st = m_status;
        st[3] = m_status[7];
        st[7] = 1'b1;
        st[12:11] = 2'b00;
        wq.push_back('{12'h300, st});
        rq.push_back('{m_epc, c0 + 4});
        m_priv = m_status[12:11];
        m_status = st;
    endtask

    task automatic do_trap(input logic [63:0] pc, cause, tval);
        exp_trap(pc, cause, tval, cyc, 1'b1);
        trap_pc = pc; trap_cause = cause; trap_tval = tval; trap_valid = 1;
        step();
        trap_valid = 0;
        chk("busy_c1", {63'd0, ready}, 64'd0);
        wait_ready();
        chk("priv_after_trap", {62'd0, priv_mode}, {62'd0, m_priv});
    endtask

    task automatic do_mret();
        exp_mret(cyc);
        mret_valid = 1;
        step();
        mret_valid = 0;
        chk("busy_c1", {63'd0, ready}, 64'd0);
        wait_ready();
        chk("priv_after_mret", {62'd0, priv_mode}, {62'd0, m_priv});
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [63:0] v);
        csr[a] = v;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 4096; i++) csr[i] = '0;
        rst = 1; trap_valid = 0; mret_valid = 0;
        trap_pc = 0; trap_cause = 0; trap_tval = 0;
        m_priv = 2'd3;
        step(); step();
        rst = 0;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_priv", {62'd0, priv_mode}, 64'd3);
        chk("rst_redir_v", {63'd0, redirect_valid}, 64'd0);
        chk("rst_redir_pc", redirect_pc, 64'd0);
        chk("rst_wden", {61'd0, wdEn, wdEn2, wdEn3}, 64'd0);
        chk("rst_rd_tgt", {52'd0, read_target}, 64'd0);
        chk("rst_wr_tgt", {28'd0, write_target, write_target2, write_target3}, 64'd0);
        chk("rst_wr_data", write_data | write_data2 | write_data3, 64'd0);

        // MRET back to M (MPP=3)
        m_status = 64'h1880; m_epc = 64'h2000; m_tvec = 64'h8000_0000;
        set_csr(12'h300, m_status); set_csr(12'h341, m_epc); set_csr(12'h305, m_tvec);
        do_mret();
        chk("mret_mstatus", csr[12'h300], 64'h88);
        // MRET with MPP=0 drops to U
        do_mret();
        chk("mret_to_u", {62'd0, priv_mode}, 64'd0);

        // Exception from U
        m_status = 64'h8; set_csr(12'h300, m_status);
        do_trap(64'h1004, 64'd2, 64'hdead);
        chk("exc_mstatus", csr[12'h300], 64'h80);
        chk("exc_mepc", csr[12'h341], 64'h1004);
        chk("exc_mtval", csr[12'h343], 64'hdead);

        // Vectored interrupt, odd pc
        m_tvec = 64'h8000_0001; set_csr(12'h305, m_tvec);
        do_trap(64'h3003, 64'h8000_0000_0000_0007, 64'h0);
        chk("vec_mepc", csr[12'h341], 64'h3002);

        // Simultaneous trap+mret; mret held while busy
        m_tvec = 64'h4000_0100; set_csr(12'h305, m_tvec);
        exp_trap(64'h5000, 64'd11, 64'h77, cyc, 1'b1);
        trap_pc = 64'h5000; trap_cause = 64'd11; trap_tval = 64'h77;
        trap_valid = 1; mret_valid = 1;
        step();
        trap_valid = 0;
        repeat (4) step();
        mret_valid = 0;
        wait_ready();
        chk("both_priv", {62'd0, priv_mode}, 64'd3);
        chk("both_wq_empty", 64'(wq.size()), 64'd0);

        // Reset in WR_TVAL: main writes stay, mtval and redirect dropped
        set_csr(12'h343, 64'h1111);
        c0 = cyc;
        exp_trap(64'h6000, 64'd5, 64'hbeef, c0, 1'b0);
        trap_pc = 64'h6000; trap_cause = 64'd5; trap_tval = 64'hbeef; trap_valid = 1;
        step();
        trap_valid = 0;
        repeat (3) step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_mid_ready", {63'd0, ready}, 64'd1);
        chk("rst_mid_priv", {62'd0, priv_mode}, 64'd3);
        chk("rst_mid_redir", {63'd0, redirect_valid}, 64'd0);
        step(); step();
        chk("rst_mid_mtval", csr[12'h343], 64'h1111);
        chk("rst_mid_mcause", csr[12'h342], 64'd5);
        chk("rst_mid_rq", 64'(rq.size()), 64'd0);

        // Back-to-back: trap_valid held, second accept at c6, redirect at c11
        c0 = cyc;
        exp_trap(64'h7000, 64'd3, 64'h1, c0, 1'b1);
        exp_trap(64'h7000, 64'd3, 64'h1, c0 + 6, 1'b1);
        trap_pc = 64'h7000; trap_cause = 64'd3; trap_tval = 64'h1; trap_valid = 1;
        step();
        chk("b2b_busy", {63'd0, ready}, 64'd0);
        repeat (5) step();
        chk("b2b_ready_c6", {63'd0, ready}, 64'd1);
        step();
        trap_valid = 0;
        wait_ready();
        step();
        chk("end_wq_empty", 64'(wq.size()), 64'd0);
        chk("end_rq_empty", 64'(rq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
